// File: rtl/mult_share_arb.sv
// -----------------------------------------------------------------------------
// mult_share_arb
//
// Purpose:
//   Round-robin arbiter and sequencer that shares one combinational 4x4
//   unsigned array multiplier among NUM_REQ requesters. A winning request
//   has its operands and ID registered. The next cycle computes the
//   product and registers it. The result is then offered on a single
//   valid/ready response channel together with the requester ID.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   [NUM_REQ]   per-requester request valid
//   req_ready   out  [NUM_REQ]   per-requester accept (one-hot or zero)
//   req_a       in   [4*NUM_REQ] multiplicands, requester i at [4i+3:4i]
//   req_b       in   [4*NUM_REQ] multipliers, same packing as req_a
//   rsp_valid   out              response valid
//   rsp_ready   in               response consumer ready
//   rsp_prod    out  [8]         unsigned product A*B
//   rsp_id      out  [ID_W]      requester that owns rsp_prod
//   stat_count  out  [16]        saturating count of response handshakes
//
// Build option:
//   MULT_ARB_STATS_EN  when defined, stat_count counts response handshakes
//                      and saturates at 16'hFFFF. When undefined, stat_count
//                      is tied to zero and no counter is built.
// -----------------------------------------------------------------------------
module mult_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [4*NUM_REQ-1:0]   req_a,
    input  logic [4*NUM_REQ-1:0]   req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [7:0]             rsp_prod,
    output logic [ID_W-1:0]        rsp_id,
    output logic [15:0]            stat_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0]      op_a_q, op_a_d;
    logic [3:0]      op_b_q, op_b_d;
    logic [ID_W-1:0] op_id_q, op_id_d;
    logic [7:0]      rsp_prod_q, rsp_prod_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic            rsp_valid_q, rsp_valid_d;

    logic            found;
    logic [ID_W-1:0] win_idx;
    logic [ID_W-1:0] cand;
    logic [3:0]      win_a;
    logic [3:0]      win_b;
    logic            accept_cycle;
    logic            grant;
    logic [7:0]      product;

    // Round-robin search: start at rr_ptr, wrap modulo NUM_REQ, and take the
    // first asserted request.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign win_a = req_a[4*win_idx +: 4];
    assign win_b = req_b[4*win_idx +: 4];

    // A grant can only happen while idle, or in the cycle a held response
    // leaves. Gating with rst_n keeps req_ready low while reset is asserted.
    assign accept_cycle = rst_n && ((state_q == IDLE) ||
                                    ((state_q == HOLD) && rsp_ready));
    assign grant        = accept_cycle && found;

    // Accept strobe goes only to the winner.
    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // Shared array multiplier: each multiplier bit gates a shifted copy of
    // the multiplicand, and the partial-product rows are summed.
    always_comb begin
        product = '0;
        for (int i = 0; i < 4; i++) begin
            if (op_b_q[i]) begin
                product = product + ({4'b0000, op_a_q} << i);
            end
        end
    end

    // Next-state logic. The operand and pointer updates follow any grant.
    // The state-specific part moves the product into the response
    // registers and releases them after the handshake.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_id_d     = op_id_q;
        rsp_prod_d  = rsp_prod_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;

        if (grant) begin
            op_a_d   = win_a;
            op_b_d   = win_b;
            op_id_d  = win_idx;
            rr_ptr_d = ID_W'((int'(win_idx) + 1) % NUM_REQ);
        end

        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                rsp_prod_d  = product;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = grant ? CALC : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= '0;
            rsp_prod_q  <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            rsp_prod_q  <= rsp_prod_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_prod  = rsp_prod_q;
    assign rsp_id    = rsp_id_q;

`ifdef MULT_ARB_STATS_EN
    logic [15:0] stat_count_q, stat_count_d;

    // Completed-transaction counter. It stops at all-ones instead of
    // wrapping.
    always_comb begin
        stat_count_d = stat_count_q;
        if (rsp_valid_q && rsp_ready && (stat_count_q != 16'hFFFF)) begin
            stat_count_d = stat_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_count_q <= 16'h0000;
        end else begin
            stat_count_q <= stat_count_d;
        end
    end

    assign stat_count = stat_count_q;
`else
    assign stat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// -----------------------------------------------------------------------------
// tb_mult_share_arb
//
// Self-checking bench for mult_share_arb with NUM_REQ=4 and ID_W=2. The bench
// applies directed vector and sequence tests, then a randomized run. The
// randomized run is checked against a transaction-level round-robin and
// scoreboard model.
// -----------------------------------------------------------------------------
module tb_mult_share_arb;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_prod;
    logic [1:0]  rsp_id;
    logic [15:0] stat_count;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         id;
        logic [7:0] prod;
    } vec_t;

    typedef struct packed {
        logic [7:0] p;
        logic [1:0] id;
    } rsp_t;

    vec_t vecs[6];
    rsp_t expQ[$];
    int   mdlPtr;
    bit   prevStall;
    logic [7:0] prevProd;
    logic [1:0] prevId;
    logic [3:0] accepted;

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    mult_share_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_prod   (rsp_prod),
        .rsp_id     (rsp_id),
        .stat_count (stat_count)
    );

    // Watchdog so a stuck design can never hang the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, summary: %0d tests run, %0d failed", testsRun, testsFailed + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // One counted comparison. A mismatch prints a FAIL line.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Inputs change 1 unit after the rising edge. Outputs are sampled on
    // the falling edge.
    task automatic toDrive();
        @(posedge clk);
        #1;
    endtask

    task automatic atNeg();
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One isolated request from one requester with rsp_ready held high. It
    // checks the same-cycle accept, the two-edge latency, the product and
    // ID, and the return to idle.
    task automatic applyStimulus(input vec_t v);
        req_valid            = 4'(1 << v.id);
        req_a[4*v.id +: 4]   = v.a;
        req_b[4*v.id +: 4]   = v.b;
        rsp_ready            = 1'b1;
        atNeg();
        checkOutput("vec accept", req_ready, 32'(1 << v.id));
        toDrive();
        req_valid = '0;
        atNeg();
        checkOutput("vec calc no valid", rsp_valid, 0);
        toDrive();
        atNeg();
        checkOutput("vec rsp valid", rsp_valid, 1);
        checkOutput("vec rsp prod", rsp_prod, v.prod);
        checkOutput("vec rsp id", rsp_id, v.id);
        toDrive();
        atNeg();
        checkOutput("vec back idle", rsp_valid, 0);
        toDrive();
    endtask

    // Transaction-level observer for the randomized run. Every grant must go
    // to the first valid requester at or after the model pointer. Every
    // response leaves in grant order with the product computed arithmetically.
    // A stalled response must stay unchanged.
    task automatic observe();
        int w;
        int idx;
        accepted = '0;
        if (rsp_valid && !rsp_ready) begin
            checkOutput("rand stall blocks grant", req_ready, 0);
        end
        if (prevStall) begin
            checkOutput("rand hold valid", rsp_valid, 1);
            checkOutput("rand hold prod", rsp_prod, prevProd);
            checkOutput("rand hold id", rsp_id, prevId);
        end
        if (rsp_valid && rsp_ready) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL rand rsp unexpected: got prod 0x%0h id %0d, expected no response", rsp_prod, rsp_id);
            end else begin
                rsp_t e;
                e = expQ.pop_front();
                checkOutput("rand rsp prod", rsp_prod, e.p);
                checkOutput("rand rsp id", rsp_id, e.id);
            end
        end
        if (req_ready != 0) begin
            w = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (mdlPtr + k) % NUM_REQ;
                if (w < 0 && req_valid[idx]) w = idx;
            end
            if (w < 0) begin
                checkOutput("rand grant without request", req_ready, 0);
            end else begin
                checkOutput("rand grant", req_ready, 32'(1) << w);
                expQ.push_back('{p: 8'(int'(req_a[4*w +: 4]) * int'(req_b[4*w +: 4])), id: 2'(w)});
                mdlPtr      = (w + 1) % NUM_REQ;
                accepted[w] = 1'b1;
            end
        end
        prevStall = rsp_valid && !rsp_ready;
        prevProd  = rsp_prod;
        prevId    = rsp_id;
    endtask

    // Main test sequence.
    initial begin
        logic [3:0] pend;
        int waitCnt[4];
        int maxWait;

        vecs[0] = '{4'd3,  4'd5,  1, 8'h0F};
        vecs[1] = '{4'd15, 4'd15, 2, 8'hE1};
        vecs[2] = '{4'd0,  4'd9,  0, 8'h00};
        vecs[3] = '{4'd8,  4'd2,  3, 8'h10};
        vecs[4] = '{4'd15, 4'd1,  1, 8'h0F};
        vecs[5] = '{4'd9,  4'd12, 2, 8'h6C};

        // Reset values, with requests present during reset.
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_a     = 16'h1234;
        req_b     = 16'h5678;
        rsp_ready = 1'b1;
        atNeg();
        checkOutput("reset req_ready", req_ready, 0);
        checkOutput("reset rsp_valid", rsp_valid, 0);
        checkOutput("reset rsp_prod", rsp_prod, 0);
        checkOutput("reset rsp_id", rsp_id, 0);
        checkOutput("reset stat_count", stat_count, 0);
        doReset();

        // Table of isolated transactions, including the operand corners.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
        end

        // All requesters valid from reset. Grants rotate 0,1,2,3,0 with one
        // result every two cycles.
        doReset();
        for (int i = 0; i < 4; i++) begin
            req_a[4*i +: 4] = 4'(i + 1);
            req_b[4*i +: 4] = 4'(i + 2);
        end
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int s = 0; s < 5; s++) begin
            int g;
            int pg;
            g  = s % 4;
            pg = (s + 3) % 4;
            atNeg();
            checkOutput("rr grant order", req_ready, 32'(1 << g));
            if (s > 0) begin
                checkOutput("rr rsp valid", rsp_valid, 1);
                checkOutput("rr rsp prod", rsp_prod, (pg + 1) * (pg + 2));
                checkOutput("rr rsp id", rsp_id, pg);
            end
            toDrive();
            atNeg();
            checkOutput("rr calc no grant", req_ready, 0);
            checkOutput("rr calc no valid", rsp_valid, 0);
            toDrive();
        end
        req_valid = '0;
        atNeg();
        checkOutput("rr last prod", rsp_prod, 8'h02);
        checkOutput("rr last id", rsp_id, 0);
        toDrive();

        // Backpressure. The response is held for 5 cycles and nobody is
        // granted. The waiting request is accepted in the handshake cycle.
        doReset();
        req_a[8 +: 4] = 4'd7;
        req_b[8 +: 4] = 4'd9;
        req_valid     = 4'b0100;
        atNeg();
        checkOutput("bp first grant", req_ready, 32'h4);
        toDrive();
        req_valid     = 4'b0001;
        req_a[0 +: 4] = 4'd4;
        req_b[0 +: 4] = 4'd6;
        atNeg();
        checkOutput("bp calc no grant", req_ready, 0);
        toDrive();
        for (int c = 0; c < 5; c++) begin
            atNeg();
            checkOutput("bp hold valid", rsp_valid, 1);
            checkOutput("bp hold prod", rsp_prod, 8'h3F);
            checkOutput("bp hold id", rsp_id, 2);
            checkOutput("bp hold no grant", req_ready, 0);
            toDrive();
        end
        rsp_ready = 1'b1;
        atNeg();
        checkOutput("bp grant on handshake", req_ready, 32'h1);
        toDrive();
        req_valid = '0;
        atNeg();
        checkOutput("bp calc valid low", rsp_valid, 0);
        toDrive();
        atNeg();
        checkOutput("bp second prod", rsp_prod, 8'h18);
        checkOutput("bp second id", rsp_id, 0);
        toDrive();
        atNeg();
        checkOutput("bp back idle", rsp_valid, 0);
        toDrive();

        // Asynchronous reset while in CALC. Outputs clear at once, no late
        // response appears, and the pointer returns to requester 0.
        req_a[8 +: 4] = 4'd5;
        req_b[8 +: 4] = 4'd5;
        req_valid     = 4'b0100;
        atNeg();
        checkOutput("ar grant", req_ready, 32'h4);
        toDrive();
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar rsp_valid", rsp_valid, 0);
        checkOutput("ar rsp_prod", rsp_prod, 0);
        checkOutput("ar rsp_id", rsp_id, 0);
        checkOutput("ar req_ready", req_ready, 0);
        toDrive();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            atNeg();
            checkOutput("ar no late response", rsp_valid, 0);
            toDrive();
        end
        req_valid = 4'b1011;
        atNeg();
        checkOutput("ar pointer reset", req_ready, 32'h1);
        toDrive();
        req_valid = '0;
        repeat (3) toDrive();

        // Statistics counter: three handshakes, then saturation when the
        // option is built, otherwise a constant zero.
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(vecs[i]);
`ifdef MULT_ARB_STATS_EN
        checkOutput("stat three", stat_count, 3);
        force dut.stat_count_q = 16'hFFFE;
        toDrive();
        release dut.stat_count_q;
        for (int i = 3; i < 6; i++) applyStimulus(vecs[i]);
        checkOutput("stat saturate", stat_count, 16'hFFFF);
`else
        checkOutput("stat disabled", stat_count, 0);
`endif

        // Randomized run against the transaction-level model.
        doReset();
        expQ.delete();
        mdlPtr    = 0;
        prevStall = 1'b0;
        pend      = '0;
        maxWait   = 0;
        for (int i = 0; i < 4; i++) waitCnt[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (accepted[i]) begin
                    pend[i]    = 1'b0;
                    waitCnt[i] = 0;
                end else if (pend[i] && $urandom_range(0, 15) == 0) begin
                    pend[i]    = 1'b0;
                    waitCnt[i] = 0;
                end
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]         = 1'b1;
                    req_a[4*i +: 4] = 4'($urandom_range(0, 15));
                    req_b[4*i +: 4] = 4'($urandom_range(0, 15));
                end
                if (pend[i]) waitCnt[i]++;
                if (waitCnt[i] > maxWait) maxWait = waitCnt[i];
            end
            req_valid = pend;
            rsp_ready = ($urandom_range(0, 3) != 0);
            atNeg();
            observe();
            toDrive();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 10 && expQ.size() != 0; c++) begin
            atNeg();
            observe();
            toDrive();
        end
        checkOutput("rand drain empty", expQ.size(), 0);
        checkOutput("rand no starvation", maxWait < 200, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
